uart_rx: RTL

Receives 8N1 serial frames on a single asynchronous line and presents each byte with a one-cycle valid strobe. It sits directly downstream of `baud_generator`: it consumes that block's `enable` pulse, which arrives at OVERSAMPLE × BAUD, as its sampling tick. The received byte and strobes feed the command decoder.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 34 +++
 rtl/uart_rx.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Summary  : Shared UART FSM state encoding and default link constants.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int C_OVERSAMPLE = 16;
    localparam int C_BAUD       = 115_200;
    localparam int C_CLOCK_HZ   = 100_000_000;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Summary  : Two-flop synchronizer for a single asynchronous input bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Summary  : Oversampling 8N1 receiver with one-cycle valid / frame_error.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = C_OVERSAMPLE,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] C_CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 w_rx_s;

    uart_state_t          r_state,  w_state_nx;
    logic [CNT_W-1:0]     r_cnt,    w_cnt_nx;
    logic [IDX_W-1:0]     r_idx,    w_idx_nx;
    logic [DATA_BITS-1:0] r_sh,     w_sh_nx;
    logic [DATA_BITS-1:0] r_data,   w_data_nx;
    logic                 r_valid,  w_valid_nx;
    logic                 r_ferr,   w_ferr_nx;
    logic                 r_busy;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sh    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_sh    <= w_sh_nx;
            r_data  <= w_data_nx;
            r_valid <= w_valid_nx;
            r_ferr  <= w_ferr_nx;
            // Tracks the next state so busy lines up with the state register.
            r_busy  <= (w_state_nx != IDLE);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_sh_nx    = r_sh;
        w_data_nx  = r_data;
        w_valid_nx = 1'b0;
        w_ferr_nx  = 1'b0;

        if (tick) begin
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nx = START;
                        w_cnt_nx   = '0;
                    end
                end
                START: begin
                    if (r_cnt == C_CNT_MID) begin
                        // A start bit that is high again at mid-bit was a glitch.
                        if (!w_rx_s) begin
                            w_state_nx = DATA;
                            w_cnt_nx   = '0;
                            w_idx_nx   = '0;
                        end else begin
                            w_state_nx = IDLE;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (r_cnt == C_CNT_LAST) begin
                        w_sh_nx  = {w_rx_s, r_sh[DATA_BITS-1:1]};
                        w_cnt_nx = '0;
                        if (r_idx == C_IDX_LAST) begin
                            w_state_nx = STOP;
                        end else begin
                            w_idx_nx = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (r_cnt == C_CNT_LAST) begin
                        w_state_nx = IDLE;
                        if (w_rx_s) begin
                            w_data_nx  = r_sh;
                            w_valid_nx = 1'b1;
                        end else begin
                            w_ferr_nx  = 1'b1;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    assign data        = r_data;
    assign valid       = r_valid;
    assign frame_error = r_ferr;
    assign busy        = r_busy;

endmodule

`default_nettype wire
